buffet_read_arbiter: RTL and testbench
======================================

# buffet_read_arbiter

- Shares one buffet read/shrink port among `NUM_REQ` consumers.
- Picks one pending request per cycle by round-robin and forwards it to the buffet's read port with its shrink and will-update qualifiers.
- Tracks which consumer owns each outstanding read so returning `read_data` goes back to the right requester.
- Sits between the buffet and the compute/consumer lanes. A buffet read stalled on a pending update back-pressures only through the shared port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_WIDTH`, `` `IDX_WIDTH ``: buffet index width.
- `DATA_WIDTH`, `` `DATA_WIDTH ``: buffet data width.
- `TAG_DEPTH`, 4: maximum outstanding reads (tag FIFO depth), power of two.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_idx` in `NUM_REQ*IDX_WIDTH`: packed per-requester index or shrink size.
- `req_is_shrink` in `NUM_REQ`: request is a shrink; it gets no response.
- `req_will_update` in `NUM_REQ`: read marks its entry for a later update.
- `req_valid` / `req_ready` in/out `NUM_REQ`: per-requester request handshake.
- `resp_data` out `DATA_WIDTH`: shared response data bus.
- `resp_valid` out `NUM_REQ`: one-hot; identifies the requester that owns `resp_data`.
- `resp_ready` in `NUM_REQ`: per-requester response ready.
- `read_idx`, `is_shrink`, `read_will_update` out `IDX_WIDTH`/1/1: to the buffet.
- `read_idx_valid` / `read_idx_ready` out/in 1: buffet request handshake.
- `read_data` in `DATA_WIDTH`; `read_data_valid` in 1; `read_data_ready` out 1: buffet response handshake.
- `outstanding` out `log2(TAG_DEPTH)+1`: current tag FIFO occupancy.
- `err_orphan` out 1: sticky; set when the buffet returns data with no tag outstanding.

## Operation
- **State:**
  - `rr_ptr` (`log2(NUM_REQ)` bits): highest-priority requester.
  - `lock` flag plus `lock_id`: a request is presented to the buffet but not yet accepted.
  - Tag FIFO: requester IDs, `TAG_DEPTH` entries; wrap-around read and write pointers, one extra bit each for full/empty.
- **Eligibility:**
  - Requester r is eligible when `req_valid[r]=1`, and either `req_is_shrink[r]=1` or the tag FIFO is not full.
  - A shrink is never blocked by a full tag FIFO.
- **Arbitration:**
  - If `lock=0`, the winner is the first eligible requester scanning from `rr_ptr` upward with wrap.
  - If `lock=1`, the winner is `lock_id`, regardless of the other requesters.
- **Forwarding** (combinational from the winner's fields):
  - `read_idx_valid=1` when a winner exists.
  - `req_ready[winner]=read_idx_ready`; all other `req_ready` bits are 0.
- **Issue:** `read_idx_valid & read_idx_ready`.
  - `rr_ptr` becomes winner+1 (mod `NUM_REQ`) and `lock` clears.
  - If the request is not a shrink, the winner ID is pushed into the tag FIFO.
- **Hold:** `read_idx_valid & !read_idx_ready`.
  - `lock` is set and `lock_id` takes the winner.
  - The presented index and qualifiers stay unchanged until accepted. Requesters must keep `req_valid` and fields stable; the block does not check this.
- **Response routing:**
  - `h` is the tag FIFO head.
  - `resp_data=read_data`.
  - `resp_valid[h]=read_data_valid` when the FIFO is not empty; 0 otherwise.
  - `read_data_ready=resp_ready[h]` when the FIFO is not empty; 1 otherwise, so orphan data is drained.
  - The FIFO pops on `read_data_valid & read_data_ready` when not empty.
- **Simultaneous push and pop:** `outstanding` is unchanged, and pushing into a full FIFO is allowed in that cycle.
- **Orphan response:** `read_data_valid=1` with the FIFO empty sets `err_orphan`. The data is dropped and `err_orphan` stays set until reset.

## Timing
- Request path: zero-cycle combinational pass-through, from `req_*` to `read_*` and from `read_idx_ready` to `req_ready`.
- Response path: zero-cycle combinational pass-through, from `read_data*` to `resp_*` and from `resp_ready` to `read_data_ready`. No added latency on either path.
- State registers update on the rising edge of `clk`. Response order equals issue order, following the buffet's in-order guarantee.
- Reset (asynchronous, `reset_i=1`):
  - `rr_ptr=0`, `lock=0`, tag FIFO empty, `outstanding=0`, `err_orphan=0`.
  - All outputs are therefore 0 (`read_idx_valid`, `req_ready`, `resp_valid`, `resp_data` follows the input) except `read_data_ready=1`.
  - Reset mid-transaction discards all tags and any lock; the buffet is reset by the same signal.
- Fairness: a continuously valid requester is issued within `NUM_REQ` accepted issues, excluding cycles spent blocked by a full tag FIFO.

## Test plan
- **Round-robin sequencing:** 4 requesters all valid, reads of idx 0,1,2,3, buffet always ready → issue order 0,1,2,3; each `resp_valid` one-hot matches its issuer with data = filled value; `outstanding` peaks ≤ 4.
- **Lock on stall:** requester 1 issues a will-update read of idx 1. Requester 2 then reads idx 1 while the buffet holds `read_idx_ready=0` for 20 cycles, and requester 3 turns valid during the stall → `read_idx` stays 1 with owner 2 throughout, `req_ready[3]=0`; after an update to idx 1, requester 2 gets the new data, then requester 3 issues.
- **Shrink interleave:** requester 0 shrinks by 2 while requester 1 reads idx 0 → the shrink pushes no tag and requester 1 alone receives the response.
- **Tag full:** `TAG_DEPTH=4`, 4 reads with all `resp_ready=0` → the 5th read is not issued, a shrink from another requester is still issued, and `outstanding=4`. Asserting `resp_ready` drains in order; simultaneous push/pop keeps `outstanding` at 4.
- **Orphan:** pulse `read_data_valid` with nothing outstanding → `err_orphan=1` and stays set.
- **Reset mid-operation:** assert `reset_i` asynchronously with 3 outstanding reads → all outputs take their reset values immediately and `outstanding=0`.

Source files
------------

// File: rtl/buffet_read_arbiter.sv
// buffet_read_arbiter: round-robin share of one buffet read/shrink port among NUM_REQ consumers,
// with an in-order tag FIFO that steers read_data back to the requester that issued it.
module buffet_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic [NUM_REQ*IDX_WIDTH-1:0]   req_idx,
    input  logic [NUM_REQ-1:0]             req_is_shrink,
    input  logic [NUM_REQ-1:0]             req_will_update,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [IDX_WIDTH-1:0]           read_idx,
    output logic                           is_shrink,
    output logic                           read_will_update,
    output logic                           read_idx_valid,
    input  logic                           read_idx_ready,
    input  logic [DATA_WIDTH-1:0]          read_data,
    input  logic                           read_data_valid,
    output logic                           read_data_ready,
    output logic [$clog2(TAG_DEPTH):0]     outstanding,
    output logic                           err_orphan
);
    localparam int RW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TAG_DEPTH);

    logic [RW-1:0]      rr_q, rr_d, lock_id_q, win, h;
    logic               lock_q, found, issue, push, pop, full, empty, err_q;
    logic [TW:0]        wr_q, rd_q;
    logic [RW-1:0]      tags_q [TAG_DEPTH];
    logic [NUM_REQ-1:0] elig;

    assign outstanding = wr_q - rd_q;
    assign empty       = wr_q == rd_q;
    assign full        = outstanding == (TW+1)'(TAG_DEPTH);
    assign h           = tags_q[rd_q[TW-1:0]];
    assign pop         = !empty && read_data_valid && resp_ready[h];
    // a full FIFO still accepts a read in the same cycle the head is popped
    assign elig        = req_valid & (req_is_shrink | {NUM_REQ{!full || pop}});

    always_comb begin
        found = 1'b0;
        win   = '0;
        if (lock_q) begin
            found = 1'b1;
            win   = lock_id_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && elig[(int'(rr_q) + i) % NUM_REQ]) begin
                    found = 1'b1;
                    win   = RW'((int'(rr_q) + i) % NUM_REQ);
                end
            end
        end
    end

    assign issue            = found && read_idx_ready;
    assign push             = issue && !req_is_shrink[win];
    assign rr_d             = (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign read_idx_valid   = found;
    assign read_idx         = found ? req_idx[win*IDX_WIDTH +: IDX_WIDTH] : '0;
    assign is_shrink        = found && req_is_shrink[win];
    assign read_will_update = found && req_will_update[win];
    assign req_ready        = found ? (NUM_REQ'(read_idx_ready) << win) : '0;
    assign resp_data        = read_data;
    assign resp_valid       = empty ? '0 : (NUM_REQ'(read_data_valid) << h);
    assign read_data_ready  = empty ? 1'b1 : resp_ready[h];
    assign err_orphan       = err_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            if (issue) begin
                rr_q   <= rr_d;
                lock_q <= 1'b0;
            end else if (found) begin
                lock_q    <= 1'b1;
                lock_id_q <= win;
            end
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (read_data_valid && empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags_q[wr_q[TW-1:0]] <= win;
    end
endmodule

// File: tb/tb_buffet_read_arbiter.sv
// tb_buffet_read_arbiter: directed scenarios with a buffet model and an owner/data scoreboard.
module tb_buffet_read_arbiter;
    logic        clk = 0, reset_i = 1;
    logic [31:0] req_idx = '0;
    logic [3:0]  req_is_shrink = '0, req_will_update = '0, req_valid = '0, req_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_valid, resp_ready = 4'hF;
    logic [7:0]  read_idx;
    logic        is_shrink, read_will_update, read_idx_valid, read_idx_ready = 1;
    logic [31:0] read_data = '0;
    logic        read_data_valid = 0, read_data_ready;
    logic [2:0]  outstanding;
    logic        err_orphan;

    buffet_read_arbiter #(.NUM_REQ(4), .IDX_WIDTH(8), .DATA_WIDTH(32), .TAG_DEPTH(4)) dut (
        .clk(clk), .reset_i(reset_i), .req_idx(req_idx), .req_is_shrink(req_is_shrink),
        .req_will_update(req_will_update), .req_valid(req_valid), .req_ready(req_ready),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .read_idx(read_idx), .is_shrink(is_shrink), .read_will_update(read_will_update),
        .read_idx_valid(read_idx_valid), .read_idx_ready(read_idx_ready),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .read_data_ready(read_data_ready), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; logic [31:0] data; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] bq[$];
    int          iss_q[$];
    logic [31:0] mem [256];
    int          nvec = 0, nerr = 0, n_shrink = 0, n_resp = 0, max_out = 0, base, v;
    bit          rd_en = 1, orphan = 0;

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic setreq(int r, int idx, bit sh, bit wu);
        req_idx[r*8 +: 8] = 8'(idx);
        req_is_shrink[r] = sh;
        req_will_update[r] = wu;
        req_valid[r] = 1'b1;
    endtask

    task automatic expect_resp(int owner, logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_resp();
        read_data_valid = orphan || (rd_en && bq.size() > 0);
        read_data = bq.size() > 0 ? bq[0] : 32'hDEAD_DEAD;
    endtask

    task automatic tick();
        logic [3:0]  iss;
        logic [31:0] d;
        exp_t        e;
        @(negedge clk);
        iss = req_valid & req_ready;
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        if (read_idx_valid && read_idx_ready) begin
            for (int r = 0; r < 4; r++) if (req_ready[r]) iss_q.push_back(r);
            if (is_shrink) n_shrink++;
            else bq.push_back(mem[read_idx]);
        end
        if (read_data_valid && read_data_ready && bq.size() > 0) begin
            d = bq.pop_front();
            n_resp++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_valid", resp_valid, 4'b1 << e.owner);
                chk("resp_data", resp_data, e.data);
            end else chk("resp_spurious", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        req_valid &= ~iss;
        drive_resp();
    endtask

    task automatic drain(string tag, int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000 + i;
        #3;
        chk("rst_idx_valid", read_idx_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rd_ready", read_data_ready, 1);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_orphan, 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 0;

        // round robin: all four valid at once
        base = iss_q.size();
        for (int r = 0; r < 4; r++) begin
            setreq(r, r, 0, 0);
            expect_resp(r, mem[r]);
        end
        drain("rr_drain", 40);
        for (int k = 0; k < 4; k++) chk("rr_order", iss_q[base + k], k);
        chk("rr_peak_le4", max_out <= 4, 1);
        chk("rr_outstanding", outstanding, 0);

        // lock on stall
        setreq(1, 1, 0, 1);
        #1;
        chk("wu_flag", read_will_update, 1);
        expect_resp(1, mem[1]);
        tick();
        read_idx_ready = 0;
        setreq(2, 1, 0, 0);
        tick();
        setreq(3, 3, 0, 0);
        v = 0;
        repeat (20) begin
            tick();
            #1;
            if (read_idx !== 8'd1 || read_idx_valid !== 1'b1 || req_ready !== 4'b0000 || read_will_update !== 1'b0) v++;
        end
        chk("lock_hold_viol", v, 0);
        chk("lock_req3_pending", req_valid[3], 1);
        mem[1] = 32'hBEEF_0001;
        base = iss_q.size();
        read_idx_ready = 1;
        expect_resp(2, mem[1]);
        expect_resp(3, mem[3]);
        drain("lock_drain", 40);
        chk("lock_first", iss_q[base], 2);
        chk("lock_second", iss_q[base + 1], 3);

        // shrink interleaved with a read
        base = n_resp;
        v = n_shrink;
        setreq(0, 2, 1, 0);
        setreq(1, 0, 0, 0);
        expect_resp(1, mem[0]);
        drain("shrink_drain", 40);
        repeat (2) tick();
        chk("shrink_resp_count", n_resp - base, 1);
        chk("shrink_issued", n_shrink - v, 1);
        chk("shrink_outstanding", outstanding, 0);

        // tag FIFO full
        rd_en = 0;
        resp_ready = 4'h0;
        base = iss_q.size();
        for (int r = 0; r < 4; r++) setreq(r, 4 + r, 0, 0);
        expect_resp(2, mem[6]);
        expect_resp(3, mem[7]);
        expect_resp(0, mem[4]);
        expect_resp(1, mem[5]);
        repeat (5) tick();
        chk("full_outstanding", outstanding, 4);
        chk("full_order0", iss_q[base], 2);
        chk("full_order3", iss_q[base + 3], 1);
        v = n_shrink;
        setreq(0, 8, 0, 0);
        setreq(2, 2, 1, 0);
        repeat (3) tick();
        chk("full_5th_blocked", req_valid[0], 1);
        chk("full_shrink_issued", n_shrink - v, 1);
        chk("full_outstanding2", outstanding, 4);
        resp_ready = 4'hF;
        rd_en = 1;
        drive_resp();
        expect_resp(0, mem[8]);
        tick();
        chk("pushpop_outstanding", outstanding, 4);
        chk("pushpop_5th_issued", req_valid[0], 0);
        drain("full_drain", 40);
        chk("full_empty", outstanding, 0);

        // orphan response
        chk("orphan_pre", err_orphan, 0);
        orphan = 1;
        drive_resp();
        #1;
        chk("orphan_rd_ready", read_data_ready, 1);
        chk("orphan_resp_valid", resp_valid, 0);
        tick();
        orphan = 0;
        drive_resp();
        chk("orphan_set", err_orphan, 1);
        repeat (3) tick();
        chk("orphan_sticky", err_orphan, 1);

        // asynchronous reset with reads in flight
        rd_en = 0;
        resp_ready = 4'h0;
        drive_resp();
        for (int r = 0; r < 3; r++) setreq(r, 10 + r, 0, 0);
        repeat (4) tick();
        chk("pre_rst_outstanding", outstanding, 3);
        read_idx_ready = 0;
        setreq(3, 13, 0, 0);
        tick();
        #2;
        reset_i = 1;
        req_valid = '0;
        #1;
        chk("arst_outstanding", outstanding, 0);
        chk("arst_idx_valid", read_idx_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_rd_ready", read_data_ready, 1);
        chk("arst_err", err_orphan, 0);
        bq.delete();
        exp_q.delete();
        drive_resp();
        repeat (2) tick();
        reset_i = 0;
        read_idx_ready = 1;
        rd_en = 1;
        resp_ready = 4'hF;
        setreq(1, 9, 0, 0);
        expect_resp(1, mem[9]);
        drain("post_rst_drain", 20);
        chk("post_rst_err", err_orphan, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
